// File: rtl/sa_ram_rws_pclr.sv
// Single-port-clock RAM with one read and one write port, byte write enables and a full-array zero clear.
// Optional output register stage enabled by defining SA_RAM_DOUT_REG_EN (2-cycle read latency).
module sa_ram_rws_pclr #(
    parameter  int DEPTH      = 512,
    parameter  int WIDTH      = 64,
    parameter  bit CLR_ON_RST = 1'b1,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NB         = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [NB-1:0]    wbe,
    input  logic [WIDTH-1:0] di,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             wr_drop,
    input  logic [31:0]      pwrbus_ram_pd
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_r [DEPTH];

    state_t           state_r;
    state_t           state_nxt_s;
    logic [AW-1:0]    cnt_r;
    logic [AW-1:0]    cnt_nxt_s;
    logic [AW-1:0]    ra_d_r;
    logic             vld_r;
    logic             wr_drop_r;
    logic             clr_busy_s;
    logic             rd_acc_s;
    logic             wr_acc_s;
    logic [WIDTH-1:0] rd_data_s;
    logic             unused_s;

    assign unused_s   = ^pwrbus_ram_pd;
    assign clr_busy_s = (state_r == CLEAR);
    assign rd_acc_s   = re & ~clr_busy_s;
    assign wr_acc_s   = we & ~clr_busy_s & ({1'b0, wa} < DEPTH_C);
    assign clr_busy   = clr_busy_s;
    assign wr_drop    = wr_drop_r;

    // Clear FSM state and address counter; reset aborts any clear in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= CLR_ON_RST ? CLEAR : IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic: a clear sweeps addresses 0..DEPTH-1, one per cycle.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (clr_req) begin
                    state_nxt_s = CLEAR;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CLEAR: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s   = cnt_r + AW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Array update: clear writes take the port; otherwise byte-masked user writes.
    always_ff @(posedge clk) begin
        if (clr_busy_s) begin
            mem_r[cnt_r] <= '0;
        end else if (wr_acc_s) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem_r[wa][8*i +: 8] <= di[8*i +: 8];
                end
            end
        end
    end

    // Read address capture, internal valid and sticky drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra_d_r    <= '0;
            vld_r     <= 1'b0;
            wr_drop_r <= 1'b0;
        end else begin
            vld_r <= rd_acc_s;
            if (rd_acc_s) begin
                ra_d_r <= ra;
            end
            if (clr_busy_s && (we || re)) begin
                wr_drop_r <= 1'b1;
            end
        end
    end

    // Reading after the write edge makes a same-address read see the new bytes.
    always_comb begin
        rd_data_s = '0;
        rd_data_s = ({1'b0, ra_d_r} < DEPTH_C) ? mem_r[ra_d_r] : '0;
    end

`ifdef SA_RAM_DOUT_REG_EN
    logic [WIDTH-1:0] dout_r;
    logic             dout_vld_r;

    // Output stage: data loads only alongside a valid read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_r     <= '0;
            dout_vld_r <= 1'b0;
        end else begin
            dout_vld_r <= vld_r;
            if (vld_r) begin
                dout_r <= rd_data_s;
            end
        end
    end

    assign dout     = dout_r;
    assign dout_vld = dout_vld_r;
`else
    assign dout     = rd_data_s;
    assign dout_vld = vld_r;
`endif

endmodule

// File: tb/tb_sa_ram_rws_pclr.sv
// Directed bench for sa_ram_rws_pclr: a DEPTH=512 and a DEPTH=300 instance driven by shared inputs.
module tb_sa_ram_rws_pclr;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  ra, wa;
    logic        re, we, clr_req;
    logic [7:0]  wbe;
    logic [63:0] di;
    logic [31:0] pwr;
    logic [63:0] dout_a, dout_b;
    logic        vld_a, vld_b, busy_a, busy_b, drop_a, drop_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic        re;
        logic [8:0]  wa;
        logic [8:0]  ra;
        logic [7:0]  wbe;
        logic [63:0] di;
        logic        sel_b;
        logic [63:0] exp_dout;
        logic        exp_vld;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    sa_ram_rws_pclr #(.DEPTH(512), .WIDTH(64), .CLR_ON_RST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_a), .dout_vld(vld_a),
        .wa(wa), .we(we), .wbe(wbe), .di(di), .clr_req(clr_req),
        .clr_busy(busy_a), .wr_drop(drop_a), .pwrbus_ram_pd(pwr)
    );

    sa_ram_rws_pclr #(.DEPTH(300), .WIDTH(64), .CLR_ON_RST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_b), .dout_vld(vld_b),
        .wa(wa), .we(we), .wbe(wbe), .di(di), .clr_req(clr_req),
        .clr_busy(busy_b), .wr_drop(drop_b), .pwrbus_ram_pd(pwr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we = 1'b0; re = 1'b0; clr_req = 1'b0;
        wa = 9'd0; ra = 9'd0; wbe = 8'h00; di = 64'h0;
    endtask

    // Counts edges until each instance drops clr_busy; 0 means it never did.
    task automatic wait_clear(output int ca, output int cb);
        ca = 0;
        cb = 0;
        for (int i = 1; i <= 1200; i++) begin
            tick();
            if (!busy_a && ca == 0) ca = i;
            if (!busy_b && cb == 0) cb = i;
            if (ca != 0 && cb != 0) break;
        end
    endtask

    function automatic vec_t mkv(input logic w, input logic r, input logic [8:0] a_w,
                                 input logic [8:0] a_r, input logic [7:0] be, input logic [63:0] d,
                                 input logic sb, input logic [63:0] ed, input logic ev);
        vec_t v;
        v.we = w; v.re = r; v.wa = a_w; v.ra = a_r; v.wbe = be; v.di = d;
        v.sel_b = sb; v.exp_dout = ed; v.exp_vld = ev;
        return v;
    endfunction

    initial begin
        int ca, cb;
        pwr = 32'h0;
        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        check("rst_busy_a", {63'd0, busy_a}, 64'd1);
        check("rst_busy_b", {63'd0, busy_b}, 64'd1);
        check("rst_vld_a",  {63'd0, vld_a},  64'd0);
        check("rst_drop_a", {63'd0, drop_a}, 64'd0);

        rst = 1'b0;
        wait_clear(ca, cb);
        check("init_clr_len_512", 64'(ca), 64'd512);
        check("init_clr_len_300", 64'(cb), 64'd300);

        vecs[0]  = mkv(1'b0, 1'b1, 9'd0,   9'd0,   8'h00, 64'h0, 1'b0, 64'h0, 1'b1);
        vecs[1]  = mkv(1'b0, 1'b1, 9'd0,   9'd511, 8'h00, 64'h0, 1'b0, 64'h0, 1'b1);
        vecs[2]  = mkv(1'b1, 1'b0, 9'd5,   9'd0,   8'hFF, 64'h1122334455667788, 1'b0, 64'h0, 1'b0);
        vecs[3]  = mkv(1'b1, 1'b0, 9'd5,   9'd0,   8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, 64'h0, 1'b0);
        vecs[4]  = mkv(1'b0, 1'b1, 9'd0,   9'd5,   8'h00, 64'h0, 1'b0, 64'h11223344AAAAAAAA, 1'b1);
        vecs[5]  = mkv(1'b0, 1'b0, 9'd0,   9'd0,   8'h00, 64'h0, 1'b0, 64'h11223344AAAAAAAA, 1'b0);
        vecs[6]  = mkv(1'b1, 1'b1, 9'd9,   9'd9,   8'hFF, 64'hDEADBEEF00000000, 1'b0, 64'hDEADBEEF00000000, 1'b1);
        vecs[7]  = mkv(1'b1, 1'b1, 9'd9,   9'd9,   8'h01, 64'h55555555555555FF, 1'b0, 64'hDEADBEEF000000FF, 1'b1);
        vecs[8]  = mkv(1'b1, 1'b0, 9'd299, 9'd0,   8'hFF, 64'h0123456789ABCDEF, 1'b1, 64'hDEADBEEF000000FF, 1'b0);
        vecs[9]  = mkv(1'b1, 1'b0, 9'd400, 9'd0,   8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hDEADBEEF000000FF, 1'b0);
        vecs[10] = mkv(1'b0, 1'b1, 9'd0,   9'd400, 8'h00, 64'h0, 1'b1, 64'h0, 1'b1);
        vecs[11] = mkv(1'b0, 1'b1, 9'd0,   9'd299, 8'h00, 64'h0, 1'b1, 64'h0123456789ABCDEF, 1'b1);

        for (int i = 0; i < 12; i++) begin
            we = vecs[i].we; re = vecs[i].re; wa = vecs[i].wa; ra = vecs[i].ra;
            wbe = vecs[i].wbe; di = vecs[i].di;
            tick();
            if (vecs[i].sel_b) begin
                check($sformatf("vec%0d_dout_b", i), dout_b, vecs[i].exp_dout);
                check($sformatf("vec%0d_vld_b", i), {63'd0, vld_b}, {63'd0, vecs[i].exp_vld});
            end else begin
                check($sformatf("vec%0d_dout_a", i), dout_a, vecs[i].exp_dout);
                check($sformatf("vec%0d_vld_a", i), {63'd0, vld_a}, {63'd0, vecs[i].exp_vld});
            end
        end
        idle_inputs();
        tick();
        check("drop_quiet_a", {63'd0, drop_a}, 64'd0);

        // Clear requested alongside a write, then accesses during the clear get dropped.
        clr_req = 1'b1; we = 1'b1; wa = 9'd3; wbe = 8'hFF; di = 64'h5555555555555555;
        tick();
        idle_inputs();
        check("clr_start_busy_a", {63'd0, busy_a}, 64'd1);
        we = 1'b1; re = 1'b1; wa = 9'd3; ra = 9'd3; wbe = 8'hFF; di = 64'h7777777777777777;
        tick();
        idle_inputs();
        check("busy_drop_a", {63'd0, drop_a}, 64'd1);
        check("busy_drop_b", {63'd0, drop_b}, 64'd1);
        check("busy_vld_a",  {63'd0, vld_a},  64'd0);
        wait_clear(ca, cb);
        check("req_clr_len_512", 64'(ca), 64'd511);
        check("req_clr_len_300", 64'(cb), 64'd299);
        re = 1'b1; ra = 9'd3;
        tick();
        idle_inputs();
        check("addr3_dout_a", dout_a, 64'h0);
        check("addr3_vld_a",  {63'd0, vld_a}, 64'd1);
        check("addr3_dout_b", dout_b, 64'h0);
        check("drop_sticky_a", {63'd0, drop_a}, 64'd1);

        // Reset partway through a clear restarts it from address 0.
        clr_req = 1'b1;
        tick();
        idle_inputs();
        repeat (100) tick();
        check("mid_clr_busy_b", {63'd0, busy_b}, 64'd1);
        rst = 1'b1;
        #1;
        check("rst_async_drop_a", {63'd0, drop_a}, 64'd0);
        check("rst_async_busy_b", {63'd0, busy_b}, 64'd1);
        tick();
        tick();
        rst = 1'b0;
        wait_clear(ca, cb);
        check("restart_clr_len_512", 64'(ca), 64'd512);
        check("restart_clr_len_300", 64'(cb), 64'd300);

        re = 1'b1; ra = 9'd9;
        tick();
        idle_inputs();
        check("post_clr_addr9_a", dout_a, 64'h0);
        check("post_clr_addr9_b", dout_b, 64'h0);
        check("post_clr_vld_b", {63'd0, vld_b}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
